// File: rtl/eva_intr_pkg.sv
// eva_intr_pkg: shared types for the EVA interrupt collector.
// Channel trigger modes and collector FSM states.
package eva_intr_pkg;

  typedef enum logic [1:0] {
    RISE  = 2'b00,
    FALL  = 2'b01,
    LEVEL = 2'b10,
    OFF   = 2'b11
  } intr_mode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GATHER  = 2'b01,
    DELIVER = 2'b10
  } intr_state_e;

  // Only edge modes can lose events, so only they track overflow.
  function automatic logic is_edge(intr_mode_e m);
    return (m == RISE) || (m == FALL);
  endfunction

endpackage

// File: rtl/eva_intr_ctrl_if.sv
// eva_intr_ctrl_if: valid/ready event port of the collector.
// master drives valid/id, slave drives ready.
interface eva_intr_ctrl_if #(
  parameter int IDW = 3
) ();

  logic           evt_valid;
  logic [IDW-1:0] evt_id;
  logic           evt_ready;

  modport master (
    output evt_valid,
    output evt_id,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_id,
    output evt_ready
  );

endinterface

// File: rtl/eva_rr_arb.sv
// eva_rr_arb: combinational NUM_CH-way round-robin picker.
// elig_i/last_i in; gnt_vld_o/gnt_id_o = first elig after last_i.
module eva_rr_arb #(
  parameter int NUM_CH = 8,
  parameter int IDW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] elig_i,
  input  logic [IDW-1:0]    last_i,
  output logic              gnt_vld_o,
  output logic [IDW-1:0]    gnt_id_o
);

  logic           hi_vld;
  logic [IDW-1:0] hi_id;
  logic           lo_vld;
  logic [IDW-1:0] lo_id;

  // Scan downward so the last hit is the lowest index:
  // hi = lowest above last, lo = lowest overall (wrap).
  always_comb begin
    hi_vld = 1'b0;
    hi_id  = '0;
    lo_vld = 1'b0;
    lo_id  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (elig_i[i]) begin
        lo_vld = 1'b1;
        lo_id  = IDW'(i);
        if (i > int'(last_i)) begin
          hi_vld = 1'b1;
          hi_id  = IDW'(i);
        end
      end
    end
  end

  assign gnt_vld_o = lo_vld;
  assign gnt_id_o  = hi_vld ? hi_id : lo_id;

endmodule

// File: rtl/eva_intr_ctrl.sv
// eva_intr_ctrl: edge/level interrupt collector with coalescing
// and round-robin delivery. Ports: clk, rst_n, irq_in, cfg_mode,
// cfg_mask, cfg_coal_thr, cfg_coal_tmo, clr_ovf, evt (master),
// pend_o, ovf_o.
module eva_intr_ctrl
  import eva_intr_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   irq_in,
  input  logic [2*NUM_CH-1:0] cfg_mode,
  input  logic [NUM_CH-1:0]   cfg_mask,
  input  logic [CNT_W-1:0]    cfg_coal_thr,
  input  logic [CNT_W-1:0]    cfg_coal_tmo,
  input  logic                clr_ovf,
  eva_intr_ctrl_if.master     evt,
  output logic [NUM_CH-1:0]   pend_o,
  output logic [NUM_CH-1:0]   ovf_o
);

  localparam int IDW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] irq_ff_q;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  intr_state_e       state_q, state_d;
  logic [CNT_W-1:0]  tmr_q, tmr_d;
  logic              vld_q, vld_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [IDW-1:0]    last_q, last_d;

  logic [NUM_CH-1:0] ev;
  logic [NUM_CH-1:0] edg;
  logic [NUM_CH-1:0] clr;
  logic [NUM_CH-1:0] elig;
  logic              hs;
  logic              imm;
  int unsigned       ecnt;
  logic              gnt_vld;
  logic [IDW-1:0]    gnt_id;

  assign hs   = vld_q & evt.evt_ready;
  assign elig = pend_q & ~cfg_mask;
  assign imm  = (cfg_coal_thr <= CNT_W'(1)) ||
                (cfg_coal_tmo == '0);

  always_comb begin
    intr_mode_e md;
    ev  = '0;
    edg = '0;
    clr = '0;
    md  = OFF;
    for (int i = 0; i < NUM_CH; i++) begin
      md     = intr_mode_e'(cfg_mode[2*i +: 2]);
      edg[i] = is_edge(md);
      clr[i] = hs && (int'(id_q) == i);
      unique case (md)
        RISE:  ev[i] = irq_in[i] & ~irq_ff_q[i];
        FALL:  ev[i] = ~irq_in[i] & irq_ff_q[i];
        LEVEL: ev[i] = irq_in[i];
        OFF:   ev[i] = 1'b0;
      endcase
    end
  end

  // An event coinciding with its own clear re-pends without
  // overflowing; a new overflow beats clr_ovf.
  always_comb begin
    logic [NUM_CH-1:0] set;
    set    = ev & edg & pend_q & ~clr;
    pend_d = (pend_q & ~clr) | ev;
    ovf_d  = (clr_ovf ? '0 : ovf_q) | set;
    ecnt   = $countones(elig);
  end

  eva_rr_arb #(
    .NUM_CH (NUM_CH),
    .IDW    (IDW)
  ) u_arb (
    .elig_i    (elig),
    .last_i    (last_q),
    .gnt_vld_o (gnt_vld),
    .gnt_id_o  (gnt_id)
  );

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    vld_d   = vld_q;
    id_d    = id_q;
    last_d  = last_q;
    if (hs) vld_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (elig != '0) begin
          if (imm) begin
            state_d = DELIVER;
          end else begin
            state_d = GATHER;
            tmr_d   = cfg_coal_tmo;
          end
        end
      end
      GATHER: begin
        if (tmr_q != '0) tmr_d = tmr_q - CNT_W'(1);
        if (elig == '0) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else if (ecnt >= 32'(cfg_coal_thr) ||
                     tmr_q == CNT_W'(1)) begin
          state_d = DELIVER;
          tmr_d   = '0;
        end
      end
      DELIVER: begin
        // A held grant stays put until its handshake,
        // whatever mask/mode do meanwhile.
        if (!vld_q) begin
          if (gnt_vld) begin
            vld_d  = 1'b1;
            id_d   = gnt_id;
            last_d = gnt_id;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_ff_q <= '0;
      pend_q   <= '0;
      ovf_q    <= '0;
      state_q  <= IDLE;
      tmr_q    <= '0;
      vld_q    <= 1'b0;
      id_q     <= '0;
      last_q   <= IDW'(NUM_CH - 1);
    end else begin
      irq_ff_q <= irq_in;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      vld_q    <= vld_d;
      id_q     <= id_d;
      last_q   <= last_d;
    end
  end

  assign evt.evt_valid = vld_q;
  assign evt.evt_id    = id_q;
  assign pend_o        = pend_q;
  assign ovf_o         = ovf_q;

endmodule

// File: tb/tb_eva_intr_ctrl.sv
// tb_eva_intr_ctrl: directed scenarios plus randomized traffic
// against a rule-level model of pending/overflow/round-robin.
module tb_eva_intr_ctrl;

  localparam int N  = 8;
  localparam int CW = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  irq = '0;
  logic [2*N-1:0] mode = '0;
  logic [N-1:0]  mask = '0;
  logic [CW-1:0] thr = '0;
  logic [CW-1:0] tmo = '0;
  logic          clr = 1'b0;
  logic [N-1:0]  pend;
  logic [N-1:0]  ovf;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int got_id[$];
  int got_cyc[$];

  always #5 clk = ~clk;

  eva_intr_ctrl_if #(.IDW(IW)) ev ();

  eva_intr_ctrl #(
    .NUM_CH (N),
    .CNT_W  (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .irq_in       (irq),
    .cfg_mode     (mode),
    .cfg_mask     (mask),
    .cfg_coal_thr (thr),
    .cfg_coal_tmo (tmo),
    .clr_ovf      (clr),
    .evt          (ev),
    .pend_o       (pend),
    .ovf_o        (ovf)
  );

  // Log every handshake with the label of its clock edge.
  always @(posedge clk) begin
    if (rst_n && ev.evt_valid && ev.evt_ready) begin
      got_id.push_back(int'(ev.evt_id));
      got_cyc.push_back(cyc);
    end
    cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    irq = '0;
    clr = 1'b0;
    ev.evt_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic int rr_pick(logic [N-1:0] s, int last);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (s[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] events_of(
    logic [N-1:0] prv, logic [N-1:0] cur, logic [2*N-1:0] md);
    logic [N-1:0] e;
    e = '0;
    for (int i = 0; i < N; i++) begin
      case (md[2*i +: 2])
        2'b00:   e[i] = cur[i] & ~prv[i];
        2'b01:   e[i] = ~cur[i] & prv[i];
        2'b10:   e[i] = cur[i];
        default: e[i] = 1'b0;
      endcase
    end
    return e;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    ev.evt_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (ev.evt_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_valid: got %b want 0", ev.evt_valid);
    end
    n_cmp++;
    if (ev.evt_id !== 3'd0) begin
      n_bad++;
      $display("FAIL rst_id: got %0d want 0", ev.evt_id);
    end
    n_cmp++;
    if (pend !== 8'h00) begin
      n_bad++;
      $display("FAIL rst_pend: got %h want 00", pend);
    end
    n_cmp++;
    if (ovf !== 8'h00) begin
      n_bad++;
      $display("FAIL rst_ovf: got %h want 00", ovf);
    end
    rst_n = 1'b1;
    mode = '0;
    mask = '0;
    thr = '0;
    tmo = '0;
    ev.evt_ready = 1'b1;
    step(2);
  endtask

  task automatic test_burst();
    int k;
    int exp_b[3] = '{1, 5, 6};
    for (int r = 0; r < 2; r++) begin
      got_id.delete();
      got_cyc.delete();
      irq = 8'b0110_0010;
      step(1);
      k = cyc - 1;
      irq = '0;
      step(10);
      n_cmp++;
      if (got_id.size() != 3) begin
        n_bad++;
        $display("FAIL burst%0d_count: got %0d want 3",
                 r, got_id.size());
      end
      for (int j = 0; j < 3; j++) begin
        if (got_id.size() > j) begin
          n_cmp++;
          if (got_id[j] != exp_b[j] ||
              got_cyc[j] != k + 3 + 2*j) begin
            n_bad++;
            $display("FAIL burst%0d_ev%0d: got id %0d @%0d want %0d @%0d",
                     r, j, got_id[j], got_cyc[j] - k,
                     exp_b[j], 3 + 2*j);
          end
        end
      end
    end
  endtask

  task automatic test_single();
    irq = 8'h08;
    step(1);
    irq = '0;
    n_cmp++;
    if (pend[3] !== 1'b1 || ev.evt_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_k: got pend3=%b valid=%b want 1 0",
               pend[3], ev.evt_valid);
    end
    step(1);
    n_cmp++;
    if (ev.evt_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_k1: got valid %b want 0", ev.evt_valid);
    end
    step(1);
    n_cmp++;
    if (ev.evt_valid !== 1'b1 || ev.evt_id !== 3'd3) begin
      n_bad++;
      $display("FAIL single_k2: got valid=%b id=%0d want 1 3",
               ev.evt_valid, ev.evt_id);
    end
    step(1);
    n_cmp++;
    if (ev.evt_valid !== 1'b0 || pend[3] !== 1'b0) begin
      n_bad++;
      $display("FAIL single_k3: got valid=%b pend3=%b want 0 0",
               ev.evt_valid, pend[3]);
    end
  endtask

  task automatic test_coalesce();
    int k;
    int exp_c[3] = '{4, 0, 2};
    thr = 8'd3;
    tmo = 8'd20;
    got_id.delete();
    got_cyc.delete();
    irq = 8'h05;
    step(1);
    k = cyc - 1;
    irq = '0;
    step(30);
    n_cmp++;
    if (got_id.size() != 2) begin
      n_bad++;
      $display("FAIL coal_tmo_count: got %0d want 2", got_id.size());
    end
    for (int j = 0; j < 2; j++) begin
      if (got_id.size() > j) begin
        n_cmp++;
        if (got_id[j] != 2*j || got_cyc[j] != k + 23 + 2*j) begin
          n_bad++;
          $display("FAIL coal_tmo_ev%0d: got id %0d @%0d want %0d @%0d",
                   j, got_id[j], got_cyc[j] - k, 2*j, 23 + 2*j);
        end
      end
    end
    got_id.delete();
    got_cyc.delete();
    irq = 8'h05;
    step(1);
    k = cyc - 1;
    irq = '0;
    step(4);
    irq = 8'h10;
    step(1);
    irq = '0;
    step(14);
    n_cmp++;
    if (got_id.size() != 3) begin
      n_bad++;
      $display("FAIL coal_thr_count: got %0d want 3", got_id.size());
    end
    for (int j = 0; j < 3; j++) begin
      if (got_id.size() > j) begin
        n_cmp++;
        if (got_id[j] != exp_c[j] || got_cyc[j] != k + 8 + 2*j) begin
          n_bad++;
          $display("FAIL coal_thr_ev%0d: got id %0d @%0d want %0d @%0d",
                   j, got_id[j], got_cyc[j] - k, exp_c[j], 8 + 2*j);
        end
      end
    end
    thr = '0;
    tmo = '0;
  endtask

  task automatic test_overflow();
    ev.evt_ready = 1'b0;
    irq = 8'h10;
    step(1);
    irq = '0;
    step(2);
    n_cmp++;
    if (ev.evt_valid !== 1'b1 || ev.evt_id !== 3'd4) begin
      n_bad++;
      $display("FAIL ovf_grant: got valid=%b id=%0d want 1 4",
               ev.evt_valid, ev.evt_id);
    end
    irq = 8'h10;
    step(1);
    irq = '0;
    n_cmp++;
    if (ovf !== 8'h10 || ev.evt_valid !== 1'b1 ||
        ev.evt_id !== 3'd4) begin
      n_bad++;
      $display("FAIL ovf_set: got ovf=%h valid=%b id=%0d want 10 1 4",
               ovf, ev.evt_valid, ev.evt_id);
    end
    step(1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    n_cmp++;
    if (ovf !== 8'h00) begin
      n_bad++;
      $display("FAIL ovf_clr: got %h want 00", ovf);
    end
    irq = 8'h10;
    clr = 1'b1;
    step(1);
    irq = '0;
    clr = 1'b0;
    n_cmp++;
    if (ovf !== 8'h10) begin
      n_bad++;
      $display("FAIL ovf_set_wins: got %h want 10", ovf);
    end
    ev.evt_ready = 1'b1;
    step(4);
    n_cmp++;
    if (pend !== 8'h00 || ev.evt_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_drain: got pend=%h valid=%b want 00 0",
               pend, ev.evt_valid);
    end
    clr = 1'b1;
    step(1);
    clr = 1'b0;
  endtask

  task automatic test_level();
    int k;
    mode[15:14] = 2'b10;
    ev.evt_ready = 1'b1;
    got_id.delete();
    got_cyc.delete();
    irq[7] = 1'b1;
    step(1);
    k = cyc - 1;
    step(6);
    mask[7] = 1'b1;
    step(3);
    irq[7] = 1'b0;
    step(4);
    n_cmp++;
    if (got_id.size() != 3) begin
      n_bad++;
      $display("FAIL level_count: got %0d want 3", got_id.size());
    end
    for (int j = 0; j < 3; j++) begin
      if (got_id.size() > j) begin
        n_cmp++;
        if (got_id[j] != 7 || got_cyc[j] != k + 3 + 2*j) begin
          n_bad++;
          $display("FAIL level_ev%0d: got id %0d @%0d want 7 @%0d",
                   j, got_id[j], got_cyc[j] - k, 3 + 2*j);
        end
      end
    end
    n_cmp++;
    if (ovf[7] !== 1'b0 || pend[7] !== 1'b1) begin
      n_bad++;
      $display("FAIL level_state: got ovf7=%b pend7=%b want 0 1",
               ovf[7], pend[7]);
    end
    mode[15:14] = 2'b00;
    mask = '0;
    step(6);
    n_cmp++;
    if (pend !== 8'h00) begin
      n_bad++;
      $display("FAIL level_cleanup: got pend %h want 00", pend);
    end
  endtask

  task automatic test_reset_mid();
    ev.evt_ready = 1'b0;
    irq = 8'h04;
    step(1);
    irq = '0;
    step(2);
    n_cmp++;
    if (ev.evt_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rmid_pre: got valid %b want 1", ev.evt_valid);
    end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ev.evt_valid !== 1'b0 || ev.evt_id !== 3'd0 ||
        pend !== 8'h00 || ovf !== 8'h00) begin
      n_bad++;
      $display("FAIL rmid_async: got v=%b id=%0d p=%h o=%h want 0 0 00 00",
               ev.evt_valid, ev.evt_id, pend, ovf);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    ev.evt_ready = 1'b1;
    got_id.delete();
    got_cyc.delete();
    step(10);
    n_cmp++;
    if (got_id.size() != 0 || pend !== 8'h00) begin
      n_bad++;
      $display("FAIL rmid_replay: got %0d events pend=%h want 0 00",
               got_id.size(), pend);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] prv, nx, pend_m, ovf_m, pold, clrv, evm, edgm;
    logic         hs, rdy, cl, was_v;
    logic [IW-1:0] old_id;
    int           last_m, exp_id, hid;
    for (int cfg = 0; cfg < 3; cfg++) begin
      do_reset();
      for (int i = 0; i < N; i++) begin
        mode[2*i +: 2] = 2'($urandom_range(0, 3));
        edgm[i] = (mode[2*i + 1] == 1'b0);
      end
      mask = N'($urandom_range(0, 255));
      thr = CW'($urandom_range(0, 3));
      tmo = CW'($urandom_range(0, 5));
      prv = '0;
      pend_m = '0;
      ovf_m = '0;
      last_m = N - 1;
      for (int c = 0; c < 300; c++) begin
        nx = prv;
        if (c < 260) begin
          for (int i = 0; i < N; i++)
            if ($urandom_range(0, 5) == 0) nx[i] = ~nx[i];
        end else begin
          nx = '0;
        end
        rdy = (c >= 260) ? 1'b1 : ($urandom_range(0, 3) != 0);
        cl = (c < 260) && ($urandom_range(0, 15) == 0);
        irq = nx;
        ev.evt_ready = rdy;
        clr = cl;
        evm = events_of(prv, nx, mode);
        was_v = ev.evt_valid;
        old_id = ev.evt_id;
        hs = was_v && rdy;
        hid = int'(old_id);
        clrv = '0;
        if (hs) begin
          n_cmp++;
          if (!(pend_m[hid] && !mask[hid])) begin
            n_bad++;
            $display("FAIL rnd_hs_elig: got id %0d pend=%h mask=%h",
                     hid, pend_m, mask);
          end
          clrv[hid] = 1'b1;
        end
        ovf_m = (cl ? '0 : ovf_m) | (evm & edgm & pend_m & ~clrv);
        pold = pend_m;
        pend_m = (pend_m & ~clrv) | evm;
        prv = nx;
        step(1);
        n_cmp++;
        if (pend !== pend_m || ovf !== ovf_m) begin
          n_bad++;
          $display("FAIL rnd_state c%0d: got p=%h o=%h want p=%h o=%h",
                   c, pend, ovf, pend_m, ovf_m);
        end
        if (was_v && !hs) begin
          n_cmp++;
          if (ev.evt_valid !== 1'b1 || ev.evt_id !== old_id) begin
            n_bad++;
            $display("FAIL rnd_hold c%0d: got v=%b id=%0d want 1 %0d",
                     c, ev.evt_valid, ev.evt_id, old_id);
          end
        end else if (!was_v && ev.evt_valid === 1'b1) begin
          exp_id = rr_pick(pold & ~mask, last_m);
          n_cmp++;
          if (int'(ev.evt_id) != exp_id) begin
            n_bad++;
            $display("FAIL rnd_pick c%0d: got %0d want %0d",
                     c, ev.evt_id, exp_id);
          end
          if (exp_id >= 0) last_m = exp_id;
        end
      end
      n_cmp++;
      if ((pend & ~mask) !== 8'h00 || ev.evt_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL rnd_drain%0d: got elig=%h v=%b want 00 0",
                 cfg, pend & ~mask, ev.evt_valid);
      end
    end
  endtask

  initial begin
    ev.evt_ready = 1'b0;
    test_reset();
    test_burst();
    test_single();
    test_coalesce();
    test_overflow();
    test_level();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
